// File: rtl/execute_stage.sv
// ---------------------------------------------------------------------------
// execute_stage
//   Execute stage of the five-stage pipeline. Evaluates single-cycle ALU ops
//   and runs a 32-step sequential multiply/divide unit (RV32M semantics) that
//   stalls the front end while it works. Drives the EX/MEM register.
//
// Ports
//   clk, rst             : clock, synchronous active-high reset
//   id_valid             : ID/EX holds a real instruction (0 = bubble)
//   id_op                : operation code (ops with bit 4 set use the mul/div unit)
//   id_a, id_b           : forwarded operands
//   id_store_data        : rs2 value for stores
//   id_WriteReg ...      : write-back / memory controls, access length and sign
//   ex_flush             : kill the instruction currently in EX
//   stall_out            : hold PC, IF/ID and ID/EX this cycle
//   EX_*                 : EX/MEM pipeline register outputs
// ---------------------------------------------------------------------------
module execute_stage #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            id_valid,
   input  logic [4:0]      id_op,
   input  logic [XLEN-1:0] id_a,
   input  logic [XLEN-1:0] id_b,
   input  logic [XLEN-1:0] id_store_data,
   input  logic [4:0]      id_WriteReg,
   input  logic            id_RegWrite,
   input  logic            id_MemtoReg,
   input  logic            id_MemRead,
   input  logic            id_MemWrite,
   input  logic [1:0]      id_length,
   input  logic            id_sign,
   input  logic            ex_flush,
   output logic            stall_out,
   output logic [XLEN-1:0] EX_ALUResult,
   output logic [XLEN-1:0] EX_din,
   output logic [4:0]      EX_WriteReg,
   output logic            EX_RegWrite,
   output logic            EX_MemtoReg,
   output logic            EX_MemRead,
   output logic            EX_MemWrite,
   output logic [1:0]      EX_length,
   output logic            EX_sign
);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t            state, state_nxt;
   logic [4:0]        cnt;
   logic              md_start;

   // Mul/div datapath state
   logic [3:0]        md_op;      // low bits of the latched op
   logic              neg_a, neg_b, b_zero;
   logic [XLEN-1:0]   md_opnd;    // multiplicand (mul) or divisor (div) magnitude
   logic [2*XLEN-1:0] work;       // {hi/remainder, lo/quotient}

   assign md_start = id_valid & id_op[4];

   // ------------------------------------------------------------------
   // Single-cycle ALU
   // ------------------------------------------------------------------
   logic [XLEN-1:0] alu_result;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      alu_result = '0;
      case (id_op)
         5'd0:    alu_result = id_a + id_b;
         5'd1:    alu_result = id_a - id_b;
         5'd2:    alu_result = id_a & id_b;
         5'd3:    alu_result = id_a | id_b;
         5'd4:    alu_result = id_a ^ id_b;
         5'd5:    alu_result = id_a << id_b[4:0];
         5'd6:    alu_result = id_a >> id_b[4:0];
         5'd7:    alu_result = $signed(id_a) >>> id_b[4:0];
         5'd8:    alu_result = {{(XLEN-1){1'b0}}, $signed(id_a) < $signed(id_b)};
         5'd9:    alu_result = {{(XLEN-1){1'b0}}, id_a < id_b};
         5'd10:   alu_result = id_b;
         default: alu_result = '0;
      endcase
   end

   // ------------------------------------------------------------------
   // Operand conditioning at start: which operands are signed per op
   // (MUL, MULH, DIV, REM: both; MULHSU: a only; unsigned ops: none).
   // ------------------------------------------------------------------
   logic            a_signed, b_signed, in_neg_a, in_neg_b;
   logic [XLEN-1:0] mag_a, mag_b;

   always_comb begin
      a_signed = 1'b0;
      b_signed = 1'b0;
      case (id_op[2:0])
         3'd0, 3'd1, 3'd4, 3'd6: begin
            a_signed = 1'b1;
            b_signed = 1'b1;
         end
         3'd2:    a_signed = 1'b1;
         default: ;
      endcase
      in_neg_a = a_signed & id_a[XLEN-1];
      in_neg_b = b_signed & id_b[XLEN-1];
      mag_a    = in_neg_a ? -id_a : id_a;
      mag_b    = in_neg_b ? -id_b : id_b;
   end

   // ------------------------------------------------------------------
   // One iteration of shift-add multiply or restoring divide
   // ------------------------------------------------------------------
   logic [XLEN:0]     mul_sum, div_rem_sh;
   logic [XLEN-1:0]   div_diff;
   logic [2*XLEN-1:0] work_step;

   always_comb begin
      mul_sum    = {1'b0, work[2*XLEN-1:XLEN]} + (work[0] ? {1'b0, md_opnd} : '0);
      div_rem_sh = {work[2*XLEN-1:XLEN], work[XLEN-1]};
      // Only used when the shifted remainder is >= divisor, so it fits XLEN bits.
      div_diff   = div_rem_sh[XLEN-1:0] - md_opnd;
      if (md_op[2]) begin
         if (div_rem_sh >= {1'b0, md_opnd})
            work_step = {div_diff, work[XLEN-2:0], 1'b1};
         else
            work_step = {div_rem_sh[XLEN-1:0], work[XLEN-2:0], 1'b0};
      end else begin
         work_step = {mul_sum, work[XLEN-1:1]};
      end
   end

   // ------------------------------------------------------------------
   // Sign fix-up and result selection (valid in DONE)
   // ------------------------------------------------------------------
   logic [2*XLEN-1:0] prod;
   logic [XLEN-1:0]   quot, rem, md_result;

   always_comb begin
      prod = (neg_a ^ neg_b) ? -work : work;
      quot = (neg_a ^ neg_b) ? -work[XLEN-1:0] : work[XLEN-1:0];
      if (b_zero)
         quot = '1;
      // Remainder follows the dividend; for x/0 this reproduces the dividend.
      rem  = neg_a ? -work[2*XLEN-1:XLEN] : work[2*XLEN-1:XLEN];
      case (md_op)
         4'd0:             md_result = prod[XLEN-1:0];
         4'd1, 4'd2, 4'd3: md_result = prod[2*XLEN-1:XLEN];
         4'd4, 4'd5:       md_result = quot;
         4'd6, 4'd7:       md_result = rem;
         default:          md_result = '0;
      endcase
   end

   // ------------------------------------------------------------------
   // FSM: state register / next state / outputs
   // ------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= (state == BUSY && !ex_flush) ? cnt + 5'd1 : 5'd0;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (md_start) state_nxt = BUSY;
         BUSY:    if (cnt == 5'd31) state_nxt = DONE;
         DONE:    state_nxt = IDLE;   // held ID/EX copy is not restarted
         default: state_nxt = IDLE;
      endcase
      if (ex_flush)
         state_nxt = IDLE;
   end

   always_comb begin
      stall_out = !rst && ((state == IDLE && md_start && !ex_flush) || state == BUSY);
   end

   // ------------------------------------------------------------------
   // Mul/div datapath registers
   // ------------------------------------------------------------------
   // NOTE: datapath registers are not reset; they are always loaded at start before being read.
   always_ff @(posedge clk) begin
      if (state == IDLE && md_start) begin
         md_op   <= id_op[3:0];
         neg_a   <= in_neg_a;
         neg_b   <= in_neg_b;
         b_zero  <= (id_b == '0);
         md_opnd <= id_op[2] ? mag_b : mag_a;
         work    <= {{XLEN{1'b0}}, (id_op[2] ? mag_a : mag_b)};
      end else if (state == BUSY) begin
         work    <= work_step;
      end
   end

   // ------------------------------------------------------------------
   // EX/MEM register; reset, flush, stall and id bubbles all load zeros
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst || ex_flush || stall_out || !id_valid) begin
         EX_ALUResult <= '0;
         EX_din       <= '0;
         EX_WriteReg  <= '0;
         EX_RegWrite  <= 1'b0;
         EX_MemtoReg  <= 1'b0;
         EX_MemRead   <= 1'b0;
         EX_MemWrite  <= 1'b0;
         EX_length    <= '0;
         EX_sign      <= 1'b0;
      end else begin
         EX_ALUResult <= (state == DONE) ? md_result : alu_result;
         EX_din       <= id_store_data;
         EX_WriteReg  <= id_WriteReg;
         EX_RegWrite  <= id_RegWrite;
         EX_MemtoReg  <= id_MemtoReg;
         EX_MemRead   <= id_MemRead;
         EX_MemWrite  <= id_MemWrite;
         EX_length    <= id_length;
         EX_sign      <= id_sign;
      end
   end

endmodule

// File: tb/tb_execute_stage.sv
// ---------------------------------------------------------------------------
// tb_execute_stage
//   Directed self-checking bench for execute_stage: reset, ALU sweep,
//   mul/div results and latency, back-to-back ops, flush in BUSY and DONE,
//   reset mid-operation, store/load control passthrough.
// ---------------------------------------------------------------------------
module tb_execute_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        id_valid;
   logic [4:0]  id_op;
   logic [31:0] id_a, id_b, id_store_data;
   logic [4:0]  id_WriteReg;
   logic        id_RegWrite, id_MemtoReg, id_MemRead, id_MemWrite;
   logic [1:0]  id_length;
   logic        id_sign;
   logic        ex_flush;
   logic        stall_out;
   logic [31:0] EX_ALUResult, EX_din;
   logic [4:0]  EX_WriteReg;
   logic        EX_RegWrite, EX_MemtoReg, EX_MemRead, EX_MemWrite;
   logic [1:0]  EX_length;
   logic        EX_sign;

   int checks   = 0;
   int failures = 0;

   execute_stage #(.XLEN(32)) dut (
      .clk(clk), .rst(rst),
      .id_valid(id_valid), .id_op(id_op), .id_a(id_a), .id_b(id_b),
      .id_store_data(id_store_data), .id_WriteReg(id_WriteReg),
      .id_RegWrite(id_RegWrite), .id_MemtoReg(id_MemtoReg),
      .id_MemRead(id_MemRead), .id_MemWrite(id_MemWrite),
      .id_length(id_length), .id_sign(id_sign), .ex_flush(ex_flush),
      .stall_out(stall_out),
      .EX_ALUResult(EX_ALUResult), .EX_din(EX_din), .EX_WriteReg(EX_WriteReg),
      .EX_RegWrite(EX_RegWrite), .EX_MemtoReg(EX_MemtoReg),
      .EX_MemRead(EX_MemRead), .EX_MemWrite(EX_MemWrite),
      .EX_length(EX_length), .EX_sign(EX_sign)
   );

   always #5 clk = ~clk;

   // Advance to just after the next rising edge.
   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [4:0] op,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] sd,
                        input logic [4:0] wr, input logic rw, input logic m2r,
                        input logic mr, input logic mw, input logic [1:0] len,
                        input logic sg);
      id_valid      = v;
      id_op         = op;
      id_a          = a;
      id_b          = b;
      id_store_data = sd;
      id_WriteReg   = wr;
      id_RegWrite   = rw;
      id_MemtoReg   = m2r;
      id_MemRead    = mr;
      id_MemWrite   = mw;
      id_length     = len;
      id_sign       = sg;
   endtask

   task automatic drive_bubble();
      drive(1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
   endtask

   // Present a mul/div op, hold it through the stall, check stall length,
   // bubbles during the stall and the final result.
   task automatic run_md(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input string name);
      int stall_cnt;
      int bad;
      drive(1'b1, op, a, b, 32'h0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0);
      #1;
      stall_cnt = 0;
      bad       = 0;
      while (stall_out === 1'b1 && stall_cnt < 40) begin
         stall_cnt++;
         cycle();
         if (EX_RegWrite !== 1'b0 || EX_MemWrite !== 1'b0 || EX_ALUResult !== 32'h0)
            bad++;
         #1;
      end
      checks++;
      if (stall_cnt !== 33) begin
         failures++;
         $display("FAIL %s_stall_cycles: got %0d expected 33", name, stall_cnt);
      end
      checks++;
      if (bad !== 0) begin
         failures++;
         $display("FAIL %s_stall_bubbles: %0d non-bubble cycles expected 0", name, bad);
      end
      cycle();
      checks++;
      if (EX_ALUResult !== exp) begin
         failures++;
         $display("FAIL %s_result: got %h expected %h", name, EX_ALUResult, exp);
      end
      checks++;
      if (EX_RegWrite !== 1'b1 || EX_WriteReg !== 5'd7) begin
         failures++;
         $display("FAIL %s_ctrl: got RegWrite=%b WriteReg=%0d expected 1/7",
                  name, EX_RegWrite, EX_WriteReg);
      end
   endtask

   task automatic test_reset();
      rst      = 1'b1;
      ex_flush = 1'b0;
      drive(1'b1, 5'd0, 32'h1, 32'h2, 32'h5, 5'd3, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 1'b1);
      for (int i = 0; i < 2; i++) begin
         cycle();
         checks++;
         if (EX_ALUResult !== 32'h0 || EX_din !== 32'h0 || EX_WriteReg !== 5'd0) begin
            failures++;
            $display("FAIL reset_data: got res=%h din=%h wr=%0d expected 0", EX_ALUResult, EX_din, EX_WriteReg);
         end
         checks++;
         if ({EX_RegWrite, EX_MemtoReg, EX_MemRead, EX_MemWrite, EX_length, EX_sign} !== 7'b0) begin
            failures++;
            $display("FAIL reset_ctrl: got %b expected 0",
                     {EX_RegWrite, EX_MemtoReg, EX_MemRead, EX_MemWrite, EX_length, EX_sign});
         end
         checks++;
         if (stall_out !== 1'b0) begin
            failures++;
            $display("FAIL reset_stall: got %b expected 0", stall_out);
         end
      end
      // A mul op under reset must not raise stall.
      drive(1'b1, 5'd16, 32'h3, 32'h3, 32'h0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0);
      #1;
      checks++;
      if (stall_out !== 1'b0) begin
         failures++;
         $display("FAIL reset_md_stall: got %b expected 0", stall_out);
      end
      drive_bubble();
      cycle();
      rst = 1'b0;
      cycle();
   endtask

   task automatic test_alu();
      logic [4:0]  ops [12];
      logic [31:0] exp [12];
      ops = '{5'd0, 5'd1, 5'd7, 5'd6, 5'd8, 5'd9, 5'd10, 5'd11, 5'd5, 5'd2, 5'd3, 5'd4};
      exp = '{32'hFFFFFFF4, 32'hFFFFFFEC, 32'hFFFFFFFF, 32'h0FFFFFFF, 32'h1, 32'h0,
              32'h4, 32'h0, 32'hFFFFFF00, 32'h0, 32'hFFFFFFF4, 32'hFFFFFFF4};
      for (int i = 0; i < 12; i++) begin
         drive(1'b1, ops[i], 32'hFFFFFFF0, 32'h4, 32'h0, 5'(i + 1), 1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0);
         #1;
         checks++;
         if (stall_out !== 1'b0) begin
            failures++;
            $display("FAIL alu_stall op=%0d: got %b expected 0", ops[i], stall_out);
         end
         cycle();
         checks++;
         if (EX_ALUResult !== exp[i]) begin
            failures++;
            $display("FAIL alu_result op=%0d: got %h expected %h", ops[i], EX_ALUResult, exp[i]);
         end
         checks++;
         if (EX_RegWrite !== 1'b1 || EX_WriteReg !== 5'(i + 1)) begin
            failures++;
            $display("FAIL alu_ctrl op=%0d: got RegWrite=%b WriteReg=%0d expected 1/%0d",
                     ops[i], EX_RegWrite, EX_WriteReg, i + 1);
         end
      end
      drive_bubble();
      cycle();
      checks++;
      if (EX_RegWrite !== 1'b0 || EX_ALUResult !== 32'h0) begin
         failures++;
         $display("FAIL alu_bubble: got RegWrite=%b res=%h expected 0/0", EX_RegWrite, EX_ALUResult);
      end
   endtask

   task automatic test_back_to_back();
      // Consecutive run_md calls present the next op in the cycle after DONE.
      run_md(5'd16, 32'hFFFFFFFD, 32'h7,        32'hFFFFFFEB, "mul");
      run_md(5'd17, 32'hFFFFFFFD, 32'h7,        32'hFFFFFFFF, "mulh");
      run_md(5'd19, 32'hFFFFFFFD, 32'h7,        32'h00000006, "mulhu");
      run_md(5'd18, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFD, "mulhsu");
      drive_bubble();
      cycle();
   endtask

   task automatic test_div();
      run_md(5'd20, 32'h7,        32'h0,        32'hFFFFFFFF, "div_by_zero");
      run_md(5'd22, 32'h7,        32'h0,        32'h00000007, "rem_by_zero");
      run_md(5'd20, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, "div_overflow");
      run_md(5'd22, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, "rem_overflow");
      run_md(5'd22, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, "rem_neg");
      run_md(5'd20, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFD, "div_neg");
      run_md(5'd21, 32'd100,      32'd7,        32'd14,       "divu");
      run_md(5'd23, 32'd100,      32'd7,        32'd2,        "remu");
      drive_bubble();
      cycle();
   endtask

   task automatic test_flush();
      int bad;
      int n;
      // ALU op flushed in EX
      drive(1'b1, 5'd0, 32'h1, 32'h2, 32'h0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0);
      ex_flush = 1'b1;
      cycle();
      ex_flush = 1'b0;
      drive_bubble();
      checks++;
      if (EX_RegWrite !== 1'b0 || EX_ALUResult !== 32'h0) begin
         failures++;
         $display("FAIL flush_alu: got RegWrite=%b res=%h expected 0/0", EX_RegWrite, EX_ALUResult);
      end
      // Flush in BUSY cycle 10
      drive(1'b1, 5'd20, 32'd100, 32'd7, 32'h0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0);
      #1;
      repeat (10) cycle();
      ex_flush = 1'b1;
      drive_bubble();
      cycle();
      ex_flush = 1'b0;
      #1;
      checks++;
      if (stall_out !== 1'b0) begin
         failures++;
         $display("FAIL flush_busy_stall: got %b expected 0", stall_out);
      end
      bad = 0;
      for (int i = 0; i < 40; i++) begin
         if (EX_RegWrite !== 1'b0) bad++;
         cycle();
      end
      checks++;
      if (bad !== 0) begin
         failures++;
         $display("FAIL flush_busy_result: %0d cycles with RegWrite=1 expected 0", bad);
      end
      // Unit must be clean afterwards
      run_md(5'd21, 32'd100, 32'd7, 32'd14, "after_flush");
      drive_bubble();
      cycle();
      // Flush in the DONE cycle
      drive(1'b1, 5'd21, 32'd100, 32'd7, 32'h0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0);
      #1;
      n = 0;
      while (stall_out === 1'b1 && n < 40) begin
         n++;
         cycle();
         #1;
      end
      checks++;
      if (n !== 33) begin
         failures++;
         $display("FAIL flush_done_reach: got %0d stall cycles expected 33", n);
      end
      ex_flush = 1'b1;
      drive_bubble();
      cycle();
      ex_flush = 1'b0;
      checks++;
      if (EX_RegWrite !== 1'b0 || EX_ALUResult !== 32'h0) begin
         failures++;
         $display("FAIL flush_done_dropped: got RegWrite=%b res=%h expected 0/0", EX_RegWrite, EX_ALUResult);
      end
      #1;
      checks++;
      if (stall_out !== 1'b0) begin
         failures++;
         $display("FAIL flush_done_stall: got %b expected 0", stall_out);
      end
   endtask

   task automatic test_reset_mid_busy();
      int bad;
      drive(1'b1, 5'd16, 32'd3, 32'd5, 32'h0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0);
      #1;
      repeat (6) cycle();
      rst = 1'b1;
      drive_bubble();
      cycle();
      rst = 1'b0;
      #1;
      checks++;
      if (EX_RegWrite !== 1'b0 || EX_ALUResult !== 32'h0 || stall_out !== 1'b0) begin
         failures++;
         $display("FAIL rst_busy: got RegWrite=%b res=%h stall=%b expected 0/0/0",
                  EX_RegWrite, EX_ALUResult, stall_out);
      end
      bad = 0;
      for (int i = 0; i < 40; i++) begin
         cycle();
         if (EX_RegWrite !== 1'b0 || stall_out !== 1'b0) bad++;
      end
      checks++;
      if (bad !== 0) begin
         failures++;
         $display("FAIL rst_busy_partial: %0d cycles with activity expected 0", bad);
      end
      run_md(5'd16, 32'd3, 32'd5, 32'd15, "after_rst");
      drive_bubble();
      cycle();
   endtask

   task automatic test_store_load();
      drive(1'b1, 5'd0, 32'h100, 32'h4, 32'hDEADBEEF, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0);
      cycle();
      drive_bubble();
      checks++;
      if (EX_ALUResult !== 32'h104 || EX_din !== 32'hDEADBEEF) begin
         failures++;
         $display("FAIL store_data: got addr=%h din=%h expected 00000104/deadbeef", EX_ALUResult, EX_din);
      end
      checks++;
      if (EX_MemWrite !== 1'b1 || EX_length !== 2'd2 || EX_RegWrite !== 1'b0) begin
         failures++;
         $display("FAIL store_ctrl: got MemWrite=%b length=%0d RegWrite=%b expected 1/2/0",
                  EX_MemWrite, EX_length, EX_RegWrite);
      end
      cycle();
      checks++;
      if (EX_MemWrite !== 1'b0) begin
         failures++;
         $display("FAIL store_once: got MemWrite=%b expected 0", EX_MemWrite);
      end
      drive(1'b1, 5'd0, 32'h200, 32'h3, 32'h0, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 1'b1);
      cycle();
      drive_bubble();
      checks++;
      if (EX_ALUResult !== 32'h203 || EX_WriteReg !== 5'd9 || EX_length !== 2'd0) begin
         failures++;
         $display("FAIL load_data: got addr=%h wr=%0d len=%0d expected 00000203/9/0",
                  EX_ALUResult, EX_WriteReg, EX_length);
      end
      checks++;
      if ({EX_RegWrite, EX_MemtoReg, EX_MemRead, EX_MemWrite, EX_sign} !== 5'b11101) begin
         failures++;
         $display("FAIL load_ctrl: got %b expected 11101",
                  {EX_RegWrite, EX_MemtoReg, EX_MemRead, EX_MemWrite, EX_sign});
      end
      cycle();
   endtask

   initial begin
      test_reset();
      test_alu();
      test_back_to_back();
      test_div();
      test_flush();
      test_reset_mid_busy();
      test_store_load();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/execute_stage.md
# execute_stage

Execute stage of the five-stage pipeline, sitting between the ID/EX register and the data-memory stage. It evaluates single-cycle ALU operations and runs a 32-iteration sequential multiply/divide unit (RV32M semantics) that stalls the front end while busy. It drives the EX/MEM pipeline register (`EX_*` outputs) consumed by the memory stage: ALU result, store data, destination register, write-back and memory controls, access length and sign.

## Interface
- `XLEN`, 32, datapath width; only 32 is supported.
- `clk` in 1: single clock; all state updates on posedge.
- `rst` in 1: reset, synchronous and active-high.
- `id_valid` in 1: ID/EX holds a real instruction (0 = bubble).
- `id_op` in 5: operation (encoding below).
- `id_a`, `id_b` in 32: forwarded operands.
- `id_store_data` in 32: rs2 value for stores.
- `id_WriteReg` in 5; `id_RegWrite`, `id_MemtoReg`, `id_MemRead`, `id_MemWrite` in 1 each; `id_length` in 2 (0 b, 1 h, 2 w); `id_sign` in 1 (0 unsigned).
- `ex_flush` in 1: kill the instruction currently in EX.
- `stall_out` out 1: hold PC, IF/ID and ID/EX this cycle.
- `EX_ALUResult` out 32, `EX_din` out 32, `EX_WriteReg` out 5, `EX_RegWrite`, `EX_MemtoReg`, `EX_MemRead`, `EX_MemWrite` out 1, `EX_length` out 2, `EX_sign` out 1: EX/MEM register.

## Operation
- Op encoding: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU, 10 PASSB (LUI); 16 MUL, 17 MULH, 18 MULHSU, 19 MULHU, 20 DIV, 21 DIVU, 22 REM, 23 REMU. Any other code yields result 0.
- Shifts use `id_b[4:0]`; SLT/SLTU return 0/1 zero-extended; ADD/SUB wrap modulo 2^32.
- Ops 0–10 are combinational, registered into EX/MEM at the next edge.
- Ops with `id_op[4]=1` use the FSM: IDLE, BUSY, DONE.
  - IDLE: on `id_valid & id_op[4]`, latch operand magnitudes, signs, op; cnt←0; go BUSY.
  - BUSY: one shift-add (mul) or restoring-subtract (div) step per cycle; cnt++; after step cnt==31, go DONE.
  - DONE: present result; go IDLE. The held ID/EX copy of the same instruction is not restarted.
- Sign fix-up in DONE: quotient negated if operand signs differ; remainder takes the dividend's sign; MULH* select the upper 32 bits of the signed/mixed 64-bit product.
- Divide by zero: quotient 0xFFFFFFFF, remainder = dividend. DIV overflow (0x80000000 / -1): quotient 0x80000000, remainder 0. Latency is unchanged in both cases.
- `stall_out = !rst & ((IDLE & id_valid & id_op[4] & !ex_flush) | BUSY)`.
- While `stall_out=1`, EX/MEM loads a bubble: all control outputs 0 (RegWrite, MemtoReg, MemRead, MemWrite), data fields 0. Repeated stores into the memory stage are therefore impossible.
- `id_valid=0` loads a bubble.
- `ex_flush`: EX/MEM loads a bubble; FSM returns to IDLE from any state. This includes DONE, where the result is discarded.
- Priority: `rst` > `ex_flush` > FSM/ALU.

## Timing
- Reset: all `EX_*` outputs 0, FSM IDLE, cnt 0, `stall_out` 0.
- ALU op: presented in cycle N, visible on `EX_*` after edge N+1. Throughput 1 per cycle.
- Mul/div op presented in cycle N:
  - `stall_out`=1 in cycles N..N+32.
  - DONE in cycle N+33, with `stall_out`=0.
  - Result on `EX_*` after edge N+34. Bubbles appear on `EX_*` after edges N+1..N+33.
- Back-to-back mul/div: the second op enters IDLE detection in cycle N+34 and stalls 33 cycles again.
- `rst` asserted mid-BUSY: next edge forces IDLE and zeroes outputs. No partial result is emitted.

## Test plan
- Reset: hold `rst` 2 cycles with `id_valid`=1, op ADD -> all `EX_*`=0 and `stall_out`=0 throughout.
- ALU sweep: a=0xFFFFFFF0, b=0x00000004 -> ADD 0xFFFFFFF4, SUB 0xFFFFFFEC, SRA 0xFFFFFFFF, SRL 0x0FFFFFFF, SLT 1, SLTU 0, each one cycle later.
- MUL/MULH: a=-3, b=7 -> MUL 0xFFFFFFEB, MULH 0xFFFFFFFF, MULHU 0x00000006.
  - Check `stall_out` high for exactly 33 cycles and bubbles (MemWrite=0) during the stall.
- DIV corner cases: DIV 7/0 -> 0xFFFFFFFF; REM 7/0 -> 7; DIV 0x80000000/-1 -> 0x80000000; REM -7/2 -> -1; DIVU 100/7 -> 14. Latency 34 cycles in every case.
- Flush: `ex_flush` in BUSY cycle 10 -> FSM IDLE, `stall_out` low next cycle, no result with RegWrite=1 emitted. Repeat with `ex_flush` in the DONE cycle -> result dropped.
- Store passthrough: SW with a=0x100, b=4, store_data 0xDEADBEEF, length 2 -> `EX_ALUResult` 0x104, `EX_din` 0xDEADBEEF, `EX_MemWrite` 1 for exactly one cycle.
